// File: rtl/memaccess_dmem_ctrl.sv
// Data-memory controller sitting behind the memaccess stage.
// One access in flight at a time, with a configurable number of wait states
// to model a slow SRAM. Results are registered and strobed with completedata.
// Optional feature macro: MEMACCESS_DMEM_PARITY_EN adds a per-word even-parity
// bit, a par_inject input and a parity_err output.
module memaccess_dmem_ctrl #(
    parameter int unsigned          DATA_W      = 16,
    parameter int unsigned          ADDR_W      = 16,
    parameter int unsigned          DEPTH_LOG2  = 10,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = 16'h3000,
    parameter int unsigned          WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              MControl,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MData,
`ifdef MEMACCESS_DMEM_PARITY_EN
    input  logic              par_inject,
    output logic              parity_err,
`endif
    output logic [DATA_W-1:0] DMem_out,
    output logic              completedata,
    output logic              busy,
    output logic              addr_err
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [ADDR_W:0] DEPTH_WORDS = (ADDR_W + 1)'(1) << DEPTH_LOG2;
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    // Value of the wait counter on the last WAIT cycle.
    localparam logic [3:0] WAIT_LAST = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Request fields captured at accept; later input changes are ignored.
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic [DATA_W-1:0] dout_q;
    logic              cd_q;
    logic              aerr_q;
    logic              aerr_pend_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic                  accept;
    logic [ADDR_W-1:0]     offset;
    logic                  mapped;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  do_write;

`ifdef MEMACCESS_DMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic pinj_q;
    logic pe_q;
    logic pe_pend_q;
`endif

    // Address decode on the latched address; subtraction wraps, so the lower
    // bound is checked explicitly to keep low addresses out of the array.
    always_comb begin
        accept   = (state_q == StIdle) && mem_req;
        offset   = addr_q - BASE_ADDR;
        mapped   = (addr_q >= BASE_ADDR) && ({1'b0, offset} < DEPTH_WORDS);
        idx      = offset[DEPTH_LOG2-1:0];
        do_write = reset && (state_q == StAccess) && wr_q && mapped;
    end

    // Next-state logic for the IDLE -> WAIT -> ACCESS -> DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    cnt_d   = 4'd0;
                    state_d = NO_WAIT ? StAccess : StWait;
                end
            end
            StWait: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAccess: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State, request capture and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            dout_q      <= '0;
            cd_q        <= 1'b0;
            aerr_q      <= 1'b0;
            aerr_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q   <= MControl;
                addr_q <= MAddr;
                data_q <= MData;
            end
            if (state_q == StAccess) begin
                aerr_pend_q <= !mapped;
                if (!wr_q) begin
                    dout_q <= mapped ? mem[idx] : '0;
                end
            end
            // Strobe appears on the cycle after DONE, as the FSM returns to IDLE.
            cd_q   <= (state_q == StDone);
            aerr_q <= (state_q == StDone) && aerr_pend_q;
        end
    end

    // Array write port; contents survive reset, and reset suppresses a pending commit.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[idx] <= data_q;
        end
    end

`ifdef MEMACCESS_DMEM_PARITY_EN
    // Parity capture, storage and check, mirroring the data path timing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pinj_q    <= 1'b0;
            pe_q      <= 1'b0;
            pe_pend_q <= 1'b0;
        end else begin
            if (accept) begin
                pinj_q <= par_inject;
            end
            if (state_q == StAccess) begin
                pe_pend_q <= mapped && !wr_q && ((^mem[idx]) != par_mem[idx]);
            end
            pe_q <= (state_q == StDone) && pe_pend_q;
        end
    end

    // Parity array write; even parity, optionally inverted to model a fault.
    always_ff @(posedge clock) begin
        if (do_write) begin
            par_mem[idx] <= (^data_q) ^ pinj_q;
        end
    end

    assign parity_err = pe_q;
`endif

    assign DMem_out     = dout_q;
    assign completedata = cd_q;
    assign addr_err     = aerr_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_memaccess_dmem_ctrl.sv
// Directed bench for memaccess_dmem_ctrl: default instance (2 wait states)
// plus 0- and 15-wait-state instances for latency corners.
module tb_memaccess_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic        mctl;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic [15:0] dout [3];
    logic        cd   [3];
    logic        bsy  [3];
    logic        aerr [3];
`ifdef MEMACCESS_DMEM_PARITY_EN
    logic        pinj;
    logic        perr [3];
    logic        pe_seen;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memaccess_dmem_ctrl #(.WAIT_STATES(2)) u_dut (
        .clock(clk), .reset(rst_n), .mem_req(req[0]), .MControl(mctl), .MAddr(maddr),
        .MData(mdata),
`ifdef MEMACCESS_DMEM_PARITY_EN
        .par_inject(pinj), .parity_err(perr[0]),
`endif
        .DMem_out(dout[0]), .completedata(cd[0]), .busy(bsy[0]), .addr_err(aerr[0])
    );

    memaccess_dmem_ctrl #(.WAIT_STATES(0)) u_dut_w0 (
        .clock(clk), .reset(rst_n), .mem_req(req[1]), .MControl(mctl), .MAddr(maddr),
        .MData(mdata),
`ifdef MEMACCESS_DMEM_PARITY_EN
        .par_inject(pinj), .parity_err(perr[1]),
`endif
        .DMem_out(dout[1]), .completedata(cd[1]), .busy(bsy[1]), .addr_err(aerr[1])
    );

    memaccess_dmem_ctrl #(.WAIT_STATES(15)) u_dut_w15 (
        .clock(clk), .reset(rst_n), .mem_req(req[2]), .MControl(mctl), .MAddr(maddr),
        .MData(mdata),
`ifdef MEMACCESS_DMEM_PARITY_EN
        .par_inject(pinj), .parity_err(perr[2]),
`endif
        .DMem_out(dout[2]), .completedata(cd[2]), .busy(bsy[2]), .addr_err(aerr[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on instance sel; lat = edges from accept to completedata, -1 on timeout.
    task automatic access(input int sel, input logic wr, input logic [15:0] addr,
                          input logic [15:0] data, output int lat,
                          output logic [15:0] rd, output logic ae);
        @(negedge clk);
        mctl     = wr;
        maddr    = addr;
        mdata    = data;
        req[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[sel] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (cd[sel]) begin
                lat = i;
                break;
            end
        end
        rd = dout[sel];
        ae = aerr[sel];
`ifdef MEMACCESS_DMEM_PARITY_EN
        pe_seen = perr[sel];
`endif
    endtask

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        ae;
        int          pulses;
        int          first_edge;
        int          last_edge;

        rst_n = 1'b0;
        req   = 3'b000;
        mctl  = 1'b0;
        maddr = 16'h0000;
        mdata = 16'h0000;
`ifdef MEMACCESS_DMEM_PARITY_EN
        pinj  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_dout", 32'(dout[0]), 32'h0);
        check("reset_cd", 32'(cd[0]), 32'h0);
        check("reset_busy", 32'(bsy[0]), 32'h0);
        check("reset_aerr", 32'(aerr[0]), 32'h0);

        // Write then read back, latency WAIT_STATES+2 = 4.
        access(0, 1'b1, 16'h3004, 16'hBEEF, lat, rd, ae);
        check("wr_lat", 32'(lat), 32'd4);
        check("wr_aerr", 32'(ae), 32'h0);
        check("wr_dout_held", 32'(rd), 32'h0);
        access(0, 1'b0, 16'h3004, 16'h0000, lat, rd, ae);
        check("rd_lat", 32'(lat), 32'd4);
        check("rd_data", 32'(rd), 32'hBEEF);
        check("rd_aerr", 32'(ae), 32'h0);

        // Unmapped accesses and array boundaries.
        access(0, 1'b1, 16'h3000, 16'h5A5A, lat, rd, ae);
        access(0, 1'b1, 16'h33FF, 16'h7777, lat, rd, ae);
        check("wr_last_aerr", 32'(ae), 32'h0);
        access(0, 1'b1, 16'h2FFF, 16'hDEAD, lat, rd, ae);
        check("wr_low_aerr", 32'(ae), 32'h1);
        access(0, 1'b1, 16'h3400, 16'hC0DE, lat, rd, ae);
        check("wr_high_aerr", 32'(ae), 32'h1);
        access(0, 1'b0, 16'h3004, 16'h0000, lat, rd, ae);
        check("rd_again", 32'(rd), 32'hBEEF);
        access(0, 1'b0, 16'h2FFF, 16'h0000, lat, rd, ae);
        check("rd_low_data", 32'(rd), 32'h0);
        check("rd_low_aerr", 32'(ae), 32'h1);
        access(0, 1'b0, 16'h3400, 16'h0000, lat, rd, ae);
        check("rd_high_data", 32'(rd), 32'h0);
        check("rd_high_aerr", 32'(ae), 32'h1);
        access(0, 1'b0, 16'hFFFF, 16'h0000, lat, rd, ae);
        check("rd_ffff_aerr", 32'(ae), 32'h1);
        access(0, 1'b0, 16'h3000, 16'h0000, lat, rd, ae);
        check("rd_base", 32'(rd), 32'h5A5A);
        check("rd_base_aerr", 32'(ae), 32'h0);
        access(0, 1'b0, 16'h33FF, 16'h0000, lat, rd, ae);
        check("rd_last", 32'(rd), 32'h7777);

        // Requests while busy are dropped; inputs only matter at accept.
        @(negedge clk);
        mctl   = 1'b0;
        maddr  = 16'h3004;
        req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_accept", 32'(bsy[0]), 32'h1);
        mctl  = 1'b1;
        maddr = 16'h2FFF;
        mdata = 16'h1111;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drop_cd", 32'(cd[0]), 32'h1);
        check("drop_data", 32'(dout[0]), 32'hBEEF);
        check("drop_aerr", 32'(aerr[0]), 32'h0);
        check("drop_busy_clear", 32'(bsy[0]), 32'h0);
        access(0, 1'b0, 16'h3004, 16'h0000, lat, rd, ae);
        check("drop_no_write", 32'(rd), 32'hBEEF);

        // Continuous requests: one strobe per WAIT_STATES+3 = 5 cycles.
        @(negedge clk);
        mctl   = 1'b0;
        maddr  = 16'h3004;
        req[0] = 1'b1;
        pulses = 0;
        first_edge = -1;
        last_edge  = -1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (cd[0]) begin
                pulses++;
                if (first_edge < 0) first_edge = e;
                last_edge = e;
            end
        end
        req[0] = 1'b0;
        check("stream_pulses", 32'(pulses), 32'd4);
        check("stream_first", 32'(first_edge), 32'd4);
        check("stream_span", 32'(last_edge - first_edge), 32'd15);
        repeat (6) @(posedge clk);

        // Reset during WAIT aborts a write.
        access(0, 1'b1, 16'h3010, 16'hAAAA, lat, rd, ae);
        access(0, 1'b0, 16'h3010, 16'h0000, lat, rd, ae);
        check("pre_reset_rd", 32'(rd), 32'hAAAA);
        @(negedge clk);
        mctl   = 1'b1;
        maddr  = 16'h3010;
        mdata  = 16'h1234;
        req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bsy[0]), 32'h0);
        check("rst_cd", 32'(cd[0]), 32'h0);
        check("rst_dout", 32'(dout[0]), 32'h0);
        rst_n  = 1'b1;
        pulses = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (cd[0]) pulses++;
        end
        check("rst_no_strobe", 32'(pulses), 32'd0);
        access(0, 1'b0, 16'h3010, 16'h0000, lat, rd, ae);
        check("rst_write_lost", 32'(rd), 32'hAAAA);

        // Latency corners.
        access(1, 1'b1, 16'h3004, 16'h1357, lat, rd, ae);
        check("w0_wr_lat", 32'(lat), 32'd2);
        access(1, 1'b0, 16'h3004, 16'h0000, lat, rd, ae);
        check("w0_rd_lat", 32'(lat), 32'd2);
        check("w0_rd_data", 32'(rd), 32'h1357);
        access(2, 1'b1, 16'h3008, 16'h2468, lat, rd, ae);
        check("w15_wr_lat", 32'(lat), 32'd17);
        access(2, 1'b0, 16'h3008, 16'h0000, lat, rd, ae);
        check("w15_rd_lat", 32'(lat), 32'd17);
        check("w15_rd_data", 32'(rd), 32'h2468);

`ifdef MEMACCESS_DMEM_PARITY_EN
        pinj = 1'b1;
        access(0, 1'b1, 16'h3020, 16'h00FF, lat, rd, ae);
        pinj = 1'b0;
        access(0, 1'b0, 16'h3020, 16'h0000, lat, rd, ae);
        check("par_bad_err", 32'(pe_seen), 32'h1);
        check("par_bad_data", 32'(rd), 32'h00FF);
        access(0, 1'b1, 16'h3020, 16'h00FF, lat, rd, ae);
        access(0, 1'b0, 16'h3020, 16'h0000, lat, rd, ae);
        check("par_good_err", 32'(pe_seen), 32'h0);
        check("par_good_data", 32'(rd), 32'h00FF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
